// File: rtl/asym_width_fifo_pkg.sv
// asym_fifo_pkg: constant helper functions shared by the asymmetric FIFO and its RAM.
// Widths are related by a power-of-two RATIO; the narrower width is the storage unit.
package asym_fifo_pkg;

  // Largest ratio between write and read widths that the FIFO is meant to support.
  localparam int MAX_RATIO = 16;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Ratio between the wide and the narrow port.
  function automatic int ratio_of(input int widthw, input int widthr);
    return max_int(widthw, widthr) / min_int(widthw, widthr);
  endfunction

  // log2 of the width ratio, i.e. how many address bits select a lane.
  function automatic int log2_ratio_of(input int widthw, input int widthr);
    return log2(ratio_of(widthw, widthr));
  endfunction

  // Narrow words consumed by one write.
  function automatic int wstep_of(input int widthw, input int widthr);
    return widthw / min_int(widthw, widthr);
  endfunction

  // Narrow words produced by one read.
  function automatic int rstep_of(input int widthw, input int widthr);
    return widthr / min_int(widthw, widthr);
  endfunction

  // True when the width pair is a legal power-of-two ratio no larger than MAX_RATIO.
  function automatic bit ratio_ok(input int widthw, input int widthr);
    int r;
    r = ratio_of(widthw, widthr);
    return (r <= MAX_RATIO) && ((1 << log2_ratio_of(widthw, widthr)) == r);
  endfunction

endpackage

// File: rtl/asym_width_fifo_sdp_ram.sv
// asym_sdp_ram: simple-dual-port RAM stored as SIZE narrow words.
// The write port and the read port may each be wide (several lanes) or narrow (one lane).
// Reads are registered; the array and the read register have no reset.
module asym_sdp_ram
  import asym_fifo_pkg::*;
#(
  parameter int WIDTHW    = 8,
  parameter int WIDTHR    = 32,
  parameter int SIZE      = 256,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [WIDTHW-1:0]    wdata,
  input  logic                 re,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [WIDTHR-1:0]    rdata
);

  localparam int MINW  = min_int(WIDTHW, WIDTHR);
  localparam int WSTEP = wstep_of(WIDTHW, WIDTHR);
  localparam int RSTEP = rstep_of(WIDTHW, WIDTHR);

  logic [MINW-1:0]      mem [SIZE];

  logic [ADDRWIDTH-1:0] wlane_addr [WSTEP];
  logic [MINW-1:0]      wlane_data [WSTEP];
  logic [ADDRWIDTH-1:0] rlane_addr [RSTEP];

  // Split a wide write into narrow lanes; lane 0 is the least significant slice.
  for (genvar k = 0; k < WSTEP; k++) begin : g_wlane
    assign wlane_addr[k] = waddr + ADDRWIDTH'(k);
    assign wlane_data[k] = wdata[k*MINW +: MINW];
  end

  // Lane addresses for a wide read; lane 0 lands in the LSBs of rdata.
  for (genvar k = 0; k < RSTEP; k++) begin : g_rlane
    assign rlane_addr[k] = raddr + ADDRWIDTH'(k);
  end

  // Narrow-word storage with all write lanes and registered read lanes on one edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < WSTEP; k++) begin
        mem[wlane_addr[k]] <= wlane_data[k];
      end
    end
    if (re) begin
      for (int k = 0; k < RSTEP; k++) begin
        rdata[k*MINW +: MINW] <= mem[rlane_addr[k]];
      end
    end
  end

endmodule

// File: rtl/asym_width_fifo.sv
// asym_width_fifo: single-clock FIFO converting WIDTHW-bit writes into WIDTHR-bit reads.
// Data is packed little-endian: the first narrow word occupies the LSBs of a wide word.
// Pointers and level count narrow words; the RAM holds SIZE narrow words.
// Build macro ASYM_FIFO_FWFT_EN selects first-word-fall-through reads; without it,
// rd_valid is a one-cycle pulse following each accepted read.
module asym_width_fifo
  import asym_fifo_pkg::*;
#(
  parameter int WIDTHW    = 8,
  parameter int WIDTHR    = 32,
  parameter int SIZE      = 256,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTHW-1:0]    din,
  output logic                 full,
  input  logic                 rd_en,
  output logic [WIDTHR-1:0]    dout,
  output logic                 rd_valid,
  output logic                 empty,
  output logic [ADDRWIDTH:0]   level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int WSTEP = wstep_of(WIDTHW, WIDTHR);
  localparam int RSTEP = rstep_of(WIDTHW, WIDTHR);

  // Step sizes at pointer width and at level width.
  localparam logic [ADDRWIDTH-1:0] WSTEP_A = ADDRWIDTH'(WSTEP);
  localparam logic [ADDRWIDTH-1:0] RSTEP_A = ADDRWIDTH'(RSTEP);
  localparam logic [ADDRWIDTH:0]   WSTEP_L = (ADDRWIDTH+1)'(WSTEP);
  localparam logic [ADDRWIDTH:0]   RSTEP_L = (ADDRWIDTH+1)'(RSTEP);
  localparam logic [ADDRWIDTH:0]   SIZE_L  = (ADDRWIDTH+1)'(SIZE);

  logic [ADDRWIDTH-1:0] wptr;
  logic [ADDRWIDTH-1:0] rptr;
  logic [ADDRWIDTH:0]   level_q;
  logic [ADDRWIDTH:0]   level_next;
  logic                 rd_valid_q;
  logic                 rd_valid_next;
  logic                 dout_loaded;
  logic                 wacc;
  logic                 ram_re;
  logic [WIDTHR-1:0]    ram_q;

  // A write needs WSTEP free narrow slots, judged on the level at the start of the cycle.
  assign full = (SIZE_L - level_q) < WSTEP_L;
  assign wacc = wr_en && !full;

`ifdef ASYM_FIFO_FWFT_EN
  // Narrow words still sitting in the RAM, i.e. not already presented on dout.
  logic [ADDRWIDTH:0] stored;
  logic               pop;

  assign stored = level_q - (rd_valid_q ? RSTEP_L : '0);
  assign pop    = rd_en && rd_valid_q;
  assign empty  = !rd_valid_q;
  // Prefetch the next head whenever dout is free or is being consumed this cycle.
  assign ram_re = (stored >= RSTEP_L) && (pop || !rd_valid_q);

  // Level counts the prefetched word, so only a pop removes RSTEP words.
  always_comb begin
    level_next    = level_q + (wacc ? WSTEP_L : '0) - (pop ? RSTEP_L : '0);
    rd_valid_next = rd_valid_q;
    if (ram_re) begin
      rd_valid_next = 1'b1;
    end else if (pop) begin
      rd_valid_next = 1'b0;
    end
  end
`else
  // Standard mode: a read needs RSTEP stored narrow words at the start of the cycle.
  assign empty  = level_q < RSTEP_L;
  assign ram_re = rd_en && !empty;

  // Level moves by both steps when a write and a read are accepted together.
  always_comb begin
    level_next    = level_q + (wacc ? WSTEP_L : '0) - (ram_re ? RSTEP_L : '0);
    rd_valid_next = ram_re;
  end
`endif

  // Storage: writes land at wptr, reads come from rptr one cycle later.
  asym_sdp_ram #(
    .WIDTHW    (WIDTHW),
    .WIDTHR    (WIDTHR),
    .SIZE      (SIZE),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wacc),
    .waddr (wptr),
    .wdata (din),
    .re    (ram_re),
    .raddr (rptr),
    .rdata (ram_q)
  );

  // Pointers advance in narrow units and wrap naturally at SIZE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wacc) wptr <= wptr + WSTEP_A;
      if (ram_re) rptr <= rptr + RSTEP_A;
    end
  end

  // Occupancy and read-valid state; reset discards any partially transferred data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      dout_loaded <= 1'b0;
    end else begin
      level_q    <= level_next;
      rd_valid_q <= rd_valid_next;
      if (ram_re) dout_loaded <= 1'b1;
    end
  end

  // Error pulses for requests made against the current-cycle flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  // The RAM read register is not reset, so dout is forced to zero until the first read.
  assign dout     = dout_loaded ? ram_q : '0;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;

endmodule

// File: tb/tb_asym_width_fifo.sv
// tb_asym_width_fifo: bench for asym_width_fifo with an 8->32 and a 32->8 instance.
// A byte-queue model predicts every output; directed literal checks pin the model.
// Honours ASYM_FIFO_FWFT_EN the same way as the design.
module tb_asym_width_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        wr0 = 1'b0, rd0 = 1'b0;
  logic [7:0]  din0 = '0;
  logic [31:0] dout0;
  logic        full0, empty0, rd_valid0, overflow0, underflow0;
  logic [8:0]  level0;

  logic        wr1 = 1'b0, rd1 = 1'b0;
  logic [31:0] din1 = '0;
  logic [7:0]  dout1;
  logic        full1, empty1, rd_valid1, overflow1, underflow1;
  logic [8:0]  level1;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asym_width_fifo #(.WIDTHW(8), .WIDTHR(32), .SIZE(256), .ADDRWIDTH(8)) u_n2w (
    .clk(clk), .rst(rst), .wr_en(wr0), .din(din0), .full(full0), .rd_en(rd0),
    .dout(dout0), .rd_valid(rd_valid0), .empty(empty0), .level(level0),
    .overflow(overflow0), .underflow(underflow0)
  );

  asym_width_fifo #(.WIDTHW(32), .WIDTHR(8), .SIZE(256), .ADDRWIDTH(8)) u_w2n (
    .clk(clk), .rst(rst), .wr_en(wr1), .din(din1), .full(full1), .rd_en(rd1),
    .dout(dout1), .rd_valid(rd_valid1), .empty(empty1), .level(level1),
    .overflow(overflow1), .underflow(underflow1)
  );

  // Model state: index 0 is the 8->32 instance, index 1 the 32->8 instance.
  logic [7:0]  mq [2][4096];
  int          mh [2];
  int          mt [2];
  bit          mvalid [2];
  logic [31:0] mdout [2];
  bit          movf [2];
  bit          munf [2];

  function automatic int wsf(int i); return (i == 0) ? 1 : 4; endfunction
  function automatic int rsf(int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int mcount(int i); return mt[i] - mh[i]; endfunction

  function automatic int mlevel(int i);
`ifdef ASYM_FIFO_FWFT_EN
    return mcount(i) + (mvalid[i] ? rsf(i) : 0);
`else
    return mcount(i);
`endif
  endfunction

  function automatic bit mfull(int i);
    return (256 - mlevel(i)) < wsf(i);
  endfunction

  function automatic bit mempty(int i);
`ifdef ASYM_FIFO_FWFT_EN
    return !mvalid[i];
`else
    return mlevel(i) < rsf(i);
`endif
  endfunction

  function automatic bit mdrained(int i);
    return (mcount(i) < rsf(i)) && mempty(i);
  endfunction

  // Take the next read word off the head of the byte queue.
  task automatic mpull(int i);
    mdout[i] = '0;
    for (int k = 0; k < rsf(i); k++) begin
      mdout[i][8*k +: 8] = mq[i][mh[i] % 4096];
      mh[i]++;
    end
  endtask

  // One clock edge of the model; flags are judged on the state before the edge.
  task automatic model_step(int i, bit we, logic [31:0] di, bit re);
    bit f, e, pop;
    f = mfull(i);
    e = mempty(i);
    pop = 1'b0;
    movf[i] = we && f;
    munf[i] = re && e;
`ifdef ASYM_FIFO_FWFT_EN
    pop = re && mvalid[i];
    if (pop || !mvalid[i]) begin
      if (mcount(i) >= rsf(i)) begin
        mpull(i);
        mvalid[i] = 1'b1;
      end else if (pop) begin
        mvalid[i] = 1'b0;
      end
    end
`else
    if (re && !e) begin
      mpull(i);
      mvalid[i] = 1'b1;
    end else begin
      mvalid[i] = 1'b0;
    end
`endif
    if (we && !f) begin
      for (int k = 0; k < wsf(i); k++) begin
        mq[i][mt[i] % 4096] = di[8*k +: 8];
        mt[i]++;
      end
    end
  endtask

  // Model update at each clock edge, cleared by the asynchronous reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mh[i] = 0; mt[i] = 0; mvalid[i] = 1'b0;
        mdout[i] = '0; movf[i] = 1'b0; munf[i] = 1'b0;
      end
    end else begin
      model_step(0, wr0, {24'h0, din0}, rd0);
      model_step(1, wr1, din1, rd1);
    end
  end

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check_output("n2w.level",     level0,     64'(mlevel(0)));
      check_output("n2w.full",      full0,      mfull(0));
      check_output("n2w.empty",     empty0,     mempty(0));
      check_output("n2w.rd_valid",  rd_valid0,  mvalid[0]);
      check_output("n2w.dout",      dout0,      mdout[0]);
      check_output("n2w.overflow",  overflow0,  movf[0]);
      check_output("n2w.underflow", underflow0, munf[0]);
      check_output("w2n.level",     level1,     64'(mlevel(1)));
      check_output("w2n.full",      full1,      mfull(1));
      check_output("w2n.empty",     empty1,     mempty(1));
      check_output("w2n.rd_valid",  rd_valid1,  mvalid[1]);
      check_output("w2n.dout",      dout1,      mdout[1][7:0]);
      check_output("w2n.overflow",  overflow1,  movf[1]);
      check_output("w2n.underflow", underflow1, munf[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read one 32-bit word from the 8->32 instance and compare it to a literal.
  task automatic read_word0(string name, logic [31:0] exp);
`ifdef ASYM_FIFO_FWFT_EN
    tick();
    check_output({name, ".valid"}, rd_valid0, 1'b1);
    check_output(name, dout0, exp);
    rd0 = 1'b1; tick(); rd0 = 1'b0;
    check_output({name, ".after"}, rd_valid0, 1'b0);
`else
    rd0 = 1'b1; tick(); rd0 = 1'b0;
    check_output({name, ".valid"}, rd_valid0, 1'b1);
    check_output(name, dout0, exp);
`endif
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [7:0] pk [4];
    logic [7:0] exp_r [4];
    int n;
    int sent;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_output("reset.level", level0, 9'd0);
    check_output("reset.empty", empty0, 1'b1);
    check_output("reset.full",  full0,  1'b0);
    check_output("reset.dout",  dout0,  32'h0);

    // Narrow-to-wide packing.
    pk = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      wr0 = 1'b1; din0 = pk[k]; tick();
      if (k == 2) begin
        check_output("pack.level3", level0, 9'd3);
        check_output("pack.empty3", empty0, 1'b1);
      end
    end
    wr0 = 1'b0;
    check_output("pack.level4", level0, 9'd4);
`ifdef ASYM_FIFO_FWFT_EN
    check_output("pack.empty4", empty0, 1'b1);
`else
    check_output("pack.empty4", empty0, 1'b0);
`endif
    read_word0("pack.dout", 32'h44332211);
    check_output("pack.level_after", level0, 9'd0);

    // Wide-to-narrow unpacking.
    wr1 = 1'b1; din1 = 32'hA1B2C3D4; tick(); wr1 = 1'b0;
    check_output("unpack.level", level1, 9'd4);
`ifdef ASYM_FIFO_FWFT_EN
    tick();
    check_output("unpack.head", dout1, 8'hD4);
    check_output("unpack.head_valid", rd_valid1, 1'b1);
    exp_r = '{8'hC3, 8'hB2, 8'hA1, 8'hA1};
`else
    exp_r = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
`endif
    rd1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output($sformatf("unpack.dout%0d", k), dout1, exp_r[k]);
      check_output($sformatf("unpack.level%0d", k), level1, 9'(3 - k));
    end
    rd1 = 1'b0;
    check_output("unpack.empty", empty1, 1'b1);

    // Underflow on the empty narrow-to-wide FIFO.
    rd0 = 1'b1; tick(); rd0 = 1'b0;
    check_output("underflow.pulse", underflow0, 1'b1);
    check_output("underflow.level", level0, 9'd0);
    check_output("underflow.dout",  dout0, 32'h44332211);
    tick();
    check_output("underflow.clear", underflow0, 1'b0);

    // Fill to capacity, then overflow.
    for (int k = 0; k < 256; k++) begin
      wr0 = 1'b1; din0 = k[7:0]; tick();
    end
    wr0 = 1'b0;
    check_output("fill.full",  full0,  1'b1);
    check_output("fill.level", level0, 9'd256);
    wr0 = 1'b1; din0 = 8'hFF; tick(); wr0 = 1'b0;
    check_output("overflow.pulse", overflow0, 1'b1);
    check_output("overflow.level", level0, 9'd256);

    // Drain to one wide word, then write and read together.
    rd0 = 1'b1; n = 0;
    while (mlevel(0) != 4 && n < 100) begin tick(); n++; end
    rd0 = 1'b0;
    check_output("drain4.level", level0, 9'd4);
    wr0 = 1'b1; rd0 = 1'b1; din0 = 8'hEE; tick(); wr0 = 1'b0; rd0 = 1'b0;
    check_output("simul.level", level0, 9'd1);

    // Random stream of incrementing bytes across the pointer wrap.
    sent = 0; n = 0;
    while (sent < 1000 && n < 20000) begin
      wr0 = ($urandom_range(0, 3) != 0);
      rd0 = ($urandom_range(0, 4) == 0);
      din0 = sent[7:0];
      if (wr0 && !mfull(0)) sent++;
      tick(); n++;
    end
    wr0 = 1'b0;
    check_output("stream.sent", 64'(sent), 64'd1000);
    rd0 = 1'b1; n = 0;
    while (!mdrained(0) && n < 1000) begin tick(); n++; end
    rd0 = 1'b0;
    tick();
    check_output("stream.drained", empty0, 1'b1);

    // Reset in the middle of traffic.
    rst = 1'b1; #2 rst = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) begin
      wr0 = 1'b1; din0 = 8'hB0 + k[7:0]; tick();
    end
    wr0 = 1'b0;
    check_output("midrst.level12", level0, 9'd12);
    wr0 = 1'b1; rd0 = 1'b1; din0 = 8'hCC; tick();
    rst = 1'b1; #2 rst = 1'b0; wr0 = 1'b0; rd0 = 1'b0;
    #1;
    check_output("midrst.level", level0, 9'd0);
    check_output("midrst.empty", empty0, 1'b1);
    check_output("midrst.dout",  dout0,  32'h0);
    check_output("midrst.valid", rd_valid0, 1'b0);

    // Refill after reset.
    pk = '{8'h55, 8'h66, 8'h77, 8'h88};
    for (int k = 0; k < 4; k++) begin
      wr0 = 1'b1; din0 = pk[k]; tick();
    end
    wr0 = 1'b0;
    read_word0("refill.dout", 32'h88776655);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
